// File: rtl/text_stream_sequencer.sv
// Sweeps char RAM line by line into a line consumer, NUM_PASSES times; one char per RAM_LATENCY+2 cycles.
// char_out/char_valid hold until sink_ready; line_done ends a line early, line_error stops the run.
module text_stream_sequencer #(
  parameter int SCREEN_WIDTH  = 64,
  parameter int SCREEN_HEIGHT = 64,
  parameter int CHAR_WIDTH    = 8,
  parameter int RAM_LATENCY   = 2,
  parameter int NUM_PASSES    = 2,
  parameter int STOP_ON_NUL   = 1,
  localparam int LCW = $clog2(SCREEN_HEIGHT + 1),
  localparam int AW  = $clog2(SCREEN_WIDTH * SCREEN_HEIGHT),
  localparam int PW  = $clog2(NUM_PASSES) + 1,
  localparam int LW  = (SCREEN_HEIGHT > 1) ? $clog2(SCREEN_HEIGHT) : 1
) (
  input  logic                  clk_pixel,
  input  logic                  sys_rst_n,
  input  logic                  start,
  input  logic                  abort,
  input  logic [LCW-1:0]        line_count,
  output logic [AW-1:0]         ram_addr,
  input  logic [CHAR_WIDTH-1:0] ram_data,
  input  logic                  sink_ready,
  input  logic                  line_done,
  input  logic                  line_error,
  output logic                  new_line,
  output logic                  char_valid,
  output logic [CHAR_WIDTH-1:0] char_out,
  output logic [PW-1:0]         pass,
  output logic [LW-1:0]         line_idx,
  output logic                  busy,
  output logic                  done,
  output logic                  error
);

  localparam int CW  = (SCREEN_WIDTH > 1) ? $clog2(SCREEN_WIDTH) : 1;
  localparam int WTW = 3;
  localparam logic [CHAR_WIDTH-1:0] NUL_CHAR = '0;
  localparam logic [CHAR_WIDTH-1:0] LF_CHAR  = CHAR_WIDTH'(10);

  typedef enum logic [2:0] {
    S_IDLE, S_LINE_START, S_FETCH, S_WAIT, S_EMIT, S_LINE_END, S_DONE, S_ERROR
  } state_t;

  state_t                state_q, state_d;
  logic [PW-1:0]         pass_q, pass_d;
  logic [LW-1:0]         line_q, line_d;
  logic [CW-1:0]         col_q, col_d;
  logic [WTW-1:0]        cnt_q, cnt_d;
  logic [LCW-1:0]        count_q, count_d;
  logic [CHAR_WIDTH-1:0] char_q, char_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;
  logic [LCW-1:0]        eff_count;
  logic                  busy_int;
  logic                  is_stop_char;

  // Reset asserts asynchronously but releases on a clock edge.
  logic [1:0] rst_sync_q;
  logic       rst_n;

  always_ff @(posedge clk_pixel or negedge sys_rst_n) begin
    if (!sys_rst_n) rst_sync_q <= '0;
    else            rst_sync_q <= {rst_sync_q[0], 1'b1};
  end
  assign rst_n = rst_sync_q[1];

  always_comb begin
    eff_count = line_count;
    if (line_count == '0 || int'(line_count) > SCREEN_HEIGHT) eff_count = LCW'(SCREEN_HEIGHT);
  end

  assign busy_int = (state_q != S_IDLE) && (state_q != S_DONE) && (state_q != S_ERROR);
  assign is_stop_char = (STOP_ON_NUL != 0) && (ram_data == NUL_CHAR || ram_data == LF_CHAR);

  always_comb begin
    state_d = state_q;
    pass_d  = pass_q;
    line_d  = line_q;
    col_d   = col_q;
    cnt_d   = cnt_q;
    count_d = count_q;
    char_d  = char_q;
    done_d  = done_q;
    err_d   = err_q;
    if (start) begin
      done_d  = 1'b0;
      err_d   = 1'b0;
      pass_d  = '0;
      line_d  = '0;
      col_d   = '0;
      count_d = eff_count;
      state_d = S_LINE_START;
    end else if (abort) begin
      state_d = S_IDLE;
    end else if (busy_int && line_error) begin
      err_d   = 1'b1;
      state_d = S_ERROR;
    end else begin
      unique case (state_q)
        S_LINE_START: begin
          col_d   = '0;
          state_d = S_FETCH;
        end
        S_FETCH: begin
          if (line_done) begin
            state_d = S_LINE_END;
          end else begin
            cnt_d   = WTW'(RAM_LATENCY - 1);
            state_d = S_WAIT;
          end
        end
        S_WAIT: begin
          if (line_done) begin
            state_d = S_LINE_END;
          end else if (cnt_q != '0) begin
            cnt_d = cnt_q - WTW'(1);
          end else if (is_stop_char) begin
            state_d = S_LINE_END;
          end else begin
            char_d  = ram_data;
            state_d = S_EMIT;
          end
        end
        S_EMIT: begin
          // A char accepted together with line_done still counts as delivered.
          if (sink_ready) begin
            if (line_done || col_q == CW'(SCREEN_WIDTH - 1)) begin
              state_d = S_LINE_END;
            end else begin
              col_d   = col_q + CW'(1);
              state_d = S_FETCH;
            end
          end else if (line_done) begin
            state_d = S_LINE_END;
          end
        end
        S_LINE_END: begin
          if (int'(line_q) + 1 < int'(count_q)) begin
            line_d  = line_q + LW'(1);
            state_d = S_LINE_START;
          end else if (int'(pass_q) < NUM_PASSES - 1) begin
            pass_d  = pass_q + PW'(1);
            line_d  = '0;
            state_d = S_LINE_START;
          end else begin
            done_d  = 1'b1;
            state_d = S_DONE;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_pixel or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      pass_q  <= '0;
      line_q  <= '0;
      col_q   <= '0;
      cnt_q   <= '0;
      count_q <= '0;
      char_q  <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pass_q  <= pass_d;
      line_q  <= line_d;
      col_q   <= col_d;
      cnt_q   <= cnt_d;
      count_q <= count_d;
      char_q  <= char_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign ram_addr   = AW'(line_q) * AW'(SCREEN_WIDTH) + AW'(col_q);
  assign new_line   = (state_q == S_LINE_START);
  assign char_valid = (state_q == S_EMIT);
  assign char_out   = char_q;
  assign pass       = pass_q;
  assign line_idx   = line_q;
  assign busy       = busy_int;
  assign done       = done_q;
  assign error      = err_q;

endmodule

// File: tb/tb_text_stream_sequencer.sv
// Directed bench for text_stream_sequencer on a 4x3 screen, RAM latency 2, two passes.
module tb_text_stream_sequencer;

  logic       clk_pixel = 1'b0;
  logic       sys_rst_n = 1'b0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic [1:0] line_count = 2'd3;
  logic [3:0] ram_addr;
  logic [7:0] ram_data;
  logic       sink_ready = 1'b1;
  logic       line_done = 1'b0;
  logic       line_error = 1'b0;
  logic       new_line;
  logic       char_valid;
  logic [7:0] char_out;
  logic [1:0] pass;
  logic [1:0] line_idx;
  logic       busy;
  logic       done;
  logic       error;

  text_stream_sequencer #(
    .SCREEN_WIDTH(4), .SCREEN_HEIGHT(3), .CHAR_WIDTH(8),
    .RAM_LATENCY(2), .NUM_PASSES(2), .STOP_ON_NUL(1)
  ) dut (
    .clk_pixel(clk_pixel), .sys_rst_n(sys_rst_n), .start(start), .abort(abort),
    .line_count(line_count), .ram_addr(ram_addr), .ram_data(ram_data),
    .sink_ready(sink_ready), .line_done(line_done), .line_error(line_error),
    .new_line(new_line), .char_valid(char_valid), .char_out(char_out),
    .pass(pass), .line_idx(line_idx), .busy(busy), .done(done), .error(error)
  );

  always #5 clk_pixel = ~clk_pixel;

  // Two-stage registered RAM: data for an address appears two edges later.
  logic [7:0] mem [0:11];
  logic [3:0] apipe0 = 4'd0;
  logic [3:0] apipe1 = 4'd0;
  always @(posedge clk_pixel) begin
    apipe0 <= ram_addr;
    apipe1 <= apipe0;
  end
  assign ram_data = (apipe1 < 4'd12) ? mem[apipe1] : 8'h00;

  logic [7:0] acc_q[$];
  int nl_cnt = 0;
  int max_addr = 0;
  int max_pass = 0;
  always @(negedge clk_pixel) begin
    if (char_valid && sink_ready) acc_q.push_back(char_out);
    if (new_line) nl_cnt++;
    if (busy && int'(ram_addr) > max_addr) max_addr = int'(ram_addr);
    if (busy && int'(pass) > max_pass) max_pass = int'(pass);
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic load(input string s);
    for (int i = 0; i < 12; i++) mem[i] = s[i];
  endtask

  // -1 on match, index of first difference, or 1000+count on length mismatch.
  function automatic int seq_diff(input int base, input string e);
    if (acc_q.size() - base != e.len()) return 1000 + acc_q.size() - base;
    for (int i = 0; i < e.len(); i++)
      if (acc_q[base + i] != e[i]) return i;
    return -1;
  endfunction

  task automatic pulse_start();
    @(posedge clk_pixel); #1 start = 1'b1;
    @(posedge clk_pixel); #1 start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    while (!(done || error) && n < 2000) begin
      @(negedge clk_pixel);
      n++;
    end
    check(tag, 32'(done), 32'd1);
  endtask

  initial begin
    int n;
    int base;
    int nl_base;
    int stable;
    load("ABCDEFGHIJKL");

    // Reset state
    #12;
    check("rst_flags", 32'({busy, done, error, new_line, char_valid}), 32'd0);
    check("rst_addr", 32'(ram_addr), 32'd0);
    check("rst_char", 32'(char_out), 32'd0);
    check("rst_pass_line", 32'({pass, line_idx}), 32'd0);
    #10 sys_rst_n = 1'b1;
    repeat (4) @(posedge clk_pixel);

    // Full run with first-char latency
    base = acc_q.size(); nl_base = nl_cnt;
    @(posedge clk_pixel); #1 start = 1'b1;
    @(negedge clk_pixel);
    check("pre_start_newline", 32'(new_line), 32'd0);
    @(posedge clk_pixel); #1 start = 1'b0;
    @(negedge clk_pixel);
    check("linestart_newline", 32'(new_line), 32'd1);
    check("linestart_busy", 32'(busy), 32'd1);
    @(negedge clk_pixel);
    check("fetch_addr", 32'(ram_addr), 32'd0);
    check("fetch_valid", 32'(char_valid), 32'd0);
    repeat (2) @(negedge clk_pixel);
    check("wait_valid", 32'(char_valid), 32'd0);
    @(negedge clk_pixel);
    check("first_char", 32'({char_valid, char_out}), 32'h141);
    wait_done("full_done");
    check("full_seq", 32'(seq_diff(base, "ABCDEFGHIJKLABCDEFGHIJKL")), 32'hFFFF_FFFF);
    check("full_newlines", 32'(nl_cnt - nl_base), 32'd6);
    check("full_busy", 32'(busy), 32'd0);
    check("full_error", 32'(error), 32'd0);
    check("full_pass_end", 32'(pass), 32'd1);
    check("full_max_addr", 32'(max_addr), 32'd11);
    check("full_max_pass", 32'(max_pass), 32'd1);

    // Backpressure on 'B'
    base = acc_q.size();
    pulse_start();
    n = 0;
    while (!(busy && ram_addr == 4'd1) && n < 300) begin @(negedge clk_pixel); n++; end
    check("bp_reach_B", 32'(n < 300), 32'd1);
    @(posedge clk_pixel); #1 sink_ready = 1'b0;
    n = 0;
    while (!char_valid && n < 20) begin @(negedge clk_pixel); n++; end
    stable = 0;
    for (int i = 0; i < 5; i++) begin
      if (char_valid && char_out == 8'h42) stable++;
      @(negedge clk_pixel);
    end
    check("bp_B_held", 32'(stable), 32'd5);
    @(posedge clk_pixel); #1 sink_ready = 1'b1;
    wait_done("bp_done");
    check("bp_seq", 32'(seq_diff(base, "ABCDEFGHIJKLABCDEFGHIJKL")), 32'hFFFF_FFFF);

    // NUL and LF terminate lines
    load("ABxDEFGHIxKL");
    mem[2] = 8'h00;
    mem[9] = 8'h0A;
    base = acc_q.size(); nl_base = nl_cnt;
    pulse_start();
    wait_done("nul_done");
    check("nul_seq", 32'(seq_diff(base, "ABEFGHIABEFGHI")), 32'hFFFF_FFFF);
    check("nul_newlines", 32'(nl_cnt - nl_base), 32'd6);

    // line_done while 'C' is pending
    load("ABCDEFGHIJKL");
    base = acc_q.size();
    pulse_start();
    n = 0;
    while (!(busy && ram_addr == 4'd2) && n < 300) begin @(negedge clk_pixel); n++; end
    @(posedge clk_pixel); #1 sink_ready = 1'b0;
    n = 0;
    while (!(char_valid && char_out == 8'h43) && n < 20) begin @(negedge clk_pixel); n++; end
    check("ld_reach_C", 32'(n < 20), 32'd1);
    @(posedge clk_pixel); #1 line_done = 1'b1;
    @(posedge clk_pixel); #1 line_done = 1'b0; sink_ready = 1'b1;
    @(negedge clk_pixel);
    check("ld_dropped", 32'({char_valid, new_line}), 32'd0);
    @(negedge clk_pixel);
    check("ld_next_line", 32'({new_line, line_idx}), 32'h5);
    wait_done("ld_done");
    check("ld_seq", 32'(seq_diff(base, "ABEFGHIJKLABCDEFGHIJKL")), 32'hFFFF_FFFF);

    // line_error in pass 1, line 2, then restart
    pulse_start();
    n = 0;
    while (!(pass == 2'd1 && line_idx == 2'd2 && char_valid) && n < 300) begin @(negedge clk_pixel); n++; end
    check("err_reach", 32'(n < 300), 32'd1);
    @(posedge clk_pixel); #1 line_error = 1'b1;
    @(posedge clk_pixel); #1 line_error = 1'b0;
    @(negedge clk_pixel);
    check("err_flags", 32'({error, done, char_valid, busy}), 32'h8);
    nl_base = nl_cnt;
    repeat (10) @(negedge clk_pixel);
    check("err_no_newline", 32'(nl_cnt - nl_base), 32'd0);
    check("err_held", 32'(error), 32'd1);
    base = acc_q.size(); nl_base = nl_cnt;
    pulse_start();
    @(negedge clk_pixel);
    check("restart_cleared", 32'({error, new_line, pass, line_idx}), 32'h10);
    wait_done("restart_done");
    check("restart_seq", 32'(seq_diff(base, "ABCDEFGHIJKLABCDEFGHIJKL")), 32'hFFFF_FFFF);
    check("restart_newlines", 32'(nl_cnt - nl_base), 32'd6);

    // line_count = 2 and line_count = 0
    line_count = 2'd2;
    base = acc_q.size(); nl_base = nl_cnt;
    pulse_start();
    wait_done("lc2_done");
    check("lc2_seq", 32'(seq_diff(base, "ABCDEFGHABCDEFGH")), 32'hFFFF_FFFF);
    check("lc2_newlines", 32'(nl_cnt - nl_base), 32'd4);
    line_count = 2'd0;
    base = acc_q.size();
    pulse_start();
    line_count = 2'd3;
    wait_done("lc0_done");
    check("lc0_seq", 32'(seq_diff(base, "ABCDEFGHIJKLABCDEFGHIJKL")), 32'hFFFF_FFFF);

    // Async reset while emitting
    pulse_start();
    n = 0;
    while (!char_valid && n < 50) begin @(negedge clk_pixel); n++; end
    check("arst_reach_emit", 32'(char_valid), 32'd1);
    #1 sys_rst_n = 1'b0;
    #1;
    check("arst_flags", 32'({busy, done, error, new_line, char_valid}), 32'd0);
    check("arst_addr_char", 32'({ram_addr, char_out}), 32'd0);
    check("arst_pass_line", 32'({pass, line_idx}), 32'd0);
    #10 sys_rst_n = 1'b1;
    repeat (4) @(posedge clk_pixel);

    // Abort mid-run
    pulse_start();
    repeat (20) @(negedge clk_pixel);
    @(posedge clk_pixel); #1 abort = 1'b1;
    @(posedge clk_pixel); #1 abort = 1'b0;
    @(negedge clk_pixel);
    check("abort_flags", 32'({busy, done, error, char_valid}), 32'd0);
    nl_base = nl_cnt;
    repeat (8) @(negedge clk_pixel);
    check("abort_idle", 32'({busy, done, error}), 32'd0);
    check("abort_no_newline", 32'(nl_cnt - nl_base), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/text_stream_sequencer.md
Name: text_stream_sequencer

Overview:
- Streams a character-RAM text buffer, line by line and column by column, into a downstream line consumer such as the assembler.
- Runs NUM_PASSES full sweeps, e.g. label/PC mapping then instruction mapping.
- Supports arbitrary RAM read latency, sink backpressure, early end-of-line, and error/abort termination.
- Sits between the text-editor RAM read port and the assembler.
- Successor to the fixed 2-pass, fixed-latency inline sequencer.

Parameters:
- SCREEN_WIDTH, 64, characters per line.
- SCREEN_HEIGHT, 64, lines in the buffer.
- CHAR_WIDTH, 8, bits per character.
- RAM_LATENCY, 2, cycles from ram_addr to valid ram_data (1..4).
- NUM_PASSES, 2, full sweeps per start (1..4).
- STOP_ON_NUL, 1, when 1 a fetched 8'h00 or 8'h0A ends the line and is not emitted.

Ports:
- clk_pixel  in  1  system clock.
- sys_rst_n  in  1  asynchronous active-low reset.
- start  in  1  single-cycle pulse; begins a run (restarts if busy).
- abort  in  1  single-cycle pulse; returns to IDLE, no done/error.
- line_count  in  $clog2(SCREEN_HEIGHT+1)  lines to stream, sampled at start; 0 or >SCREEN_HEIGHT is treated as SCREEN_HEIGHT.
- ram_addr  out  $clog2(SCREEN_WIDTH*SCREEN_HEIGHT)  equals line*SCREEN_WIDTH+col.
- ram_data  in  CHAR_WIDTH  RAM read data.
- sink_ready  in  1  consumer accepts char when char_valid&&sink_ready.
- line_done  in  1  consumer finished the current line early.
- line_error  in  1  consumer error.
- new_line  out  1  one-cycle pulse before the first char of each line.
- char_valid  out  1  char_out is valid.
- char_out  out  CHAR_WIDTH  character to the consumer.
- pass  out  $clog2(NUM_PASSES)+1  current pass index (0-based).
- line_idx  out  $clog2(SCREEN_HEIGHT)  current line.
- busy  out  1  high in any non-IDLE/DONE/ERROR state.
- done  out  1  held high after a successful run until the next start.
- error  out  1  held high after line_error until the next start.

Behaviour:
- Reset (async assert, sync deassert internally): state=IDLE. All outputs are 0: ram_addr, char_out, pass, line_idx, new_line, char_valid, busy, done, error.
- States: IDLE, LINE_START, FETCH, WAIT, EMIT, LINE_END, DONE, ERROR.
- start (any state, highest priority after reset):
  - Clears done/error.
  - Sets pass=0, line=0, col=0.
  - Latches the effective line count → LINE_START next cycle.
- abort (lower than start): → IDLE next cycle. Counters are held; done/error are unchanged.
- line_error in any busy state → ERROR; error=1, char_valid=0. This takes priority over line_done and over end of line.
- LINE_START: new_line=1 for exactly this cycle; col=0 → FETCH.
- FETCH: drive ram_addr → WAIT. Wait RAM_LATENCY-1 further cycles, so ram_data is sampled exactly RAM_LATENCY cycles after ram_addr was first driven. ram_addr is stable throughout.
- Sampling: if STOP_ON_NUL and the sampled char is 0x00 or 0x0A → LINE_END, nothing emitted. Otherwise latch into char_out and set char_valid=1 → EMIT.
- EMIT: char_out/char_valid are held until sink_ready.
  - On accept: if col==SCREEN_WIDTH-1 → LINE_END; else col+1 → FETCH.
  - Max throughput is one char per RAM_LATENCY+2 cycles.
- line_done in FETCH/WAIT/EMIT → LINE_END next cycle; any pending char is dropped (char_valid=0).
- line_done coincident with accept: the char counts as accepted, then → LINE_END.
- LINE_END:
  - If line < count-1: line+1 → LINE_START.
  - Else if pass < NUM_PASSES-1: pass+1, line=0 → LINE_START.
  - Else → DONE; done=1, busy=0.
- No wrap: col never exceeds SCREEN_WIDTH-1, line never exceeds count-1. ram_addr width is exact, with no overflow at the last cell.
- line_done/line_error/sink_ready are ignored in IDLE/DONE/ERROR.
- sys_rst_n asserted mid-run → IDLE immediately, outputs cleared asynchronously.

Test Plan (WIDTH=4, HEIGHT=3, LATENCY=2, PASSES=2, STOP_ON_NUL=1):
- Full run, RAM "ABCD","EFGH","IJKL", sink_ready=1 → 24 accepted chars A..L twice, 6 new_line pulses, pass 0→1, then done=1 and busy=0.
- Backpressure: sink_ready low 5 cycles at char 'B' → char_valid/char_out='B' held stable, no duplicates or drops, final sequence unchanged.
- Early end: line 0 "AB\0D" → A,B emitted, D skipped, line 1 starts. Separately, line_done pulsed while 'C' pending → C dropped, new_line next.
- line_error during pass 1 line 2 → error=1, done=0, char_valid=0, no further new_line. start then clears error and restarts at pass 0.
- line_count=2 → only lines 0–1 streamed per pass, 16 chars total. line_count=0 → all 3 lines.
- Async: sys_rst_n low mid-EMIT → all outputs 0 without a clock edge. abort mid-run → IDLE, done/error stay 0.
